// File: rtl/gcm_tag_check.sv
// gcm_tag_check -- GCM GHASH accumulator and tag verifier.
//
// Absorbs one 128-bit AAD or ciphertext block per accepted beat. Each beat
// is folded into the running hash Y and multiplied by H. After the i_last
// beat, the length block is folded in and multiplied. The tag Y ^ E(K,J0)
// is then compared against the received tag.
//
// The GF(2^128) multiply is a shift-and-add. BITS_PER_CYCLE multiplier bits
// are consumed per clock, so one multiply takes 128/BITS_PER_CYCLE cycles.
// Legal values of BITS_PER_CYCLE: 1, 2, 4, 8, 16, 32.
//
// Internally every 128-bit quantity is held as [127:0], with bit 127 equal
// to GCM bit 0 (the MSB). The [0:127] ports map positionally onto this, so
// no bit reversal is needed anywhere.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   i_start          open a session (honoured in IDLE/DONE only)
//   i_h              hash subkey H, latched with an accepted i_start
//   i_encrypted_j0   E(K,J0), latched with an accepted i_start
//   i_valid/o_ready  beat handshake (o_ready only in WAIT)
//   i_data           AAD/ciphertext block
//   i_is_aad         block kind
//   i_last           final block of the message
//   i_tag            received tag, sampled with the i_last beat
//   o_tag            computed tag
//   o_auth_ok        o_tag matches the received tag
//   o_done           one-cycle pulse when o_tag/o_auth_ok become valid
//   o_busy           session in progress

// One clock's worth of the GF(2^128) multiply. Z accumulates V wherever the
// multiplier bit is set. V is multiplied by x on every step, which in the
// reflected GCM representation is a right shift with a conditional R
// reduction.
module gcm_gf_round #(
  parameter int BITS = 8
) (
  input  logic [127:0] z_i,
  input  logic [127:0] v_i,
  input  logic [127:0] x_i,   // multiplier; bit 127 is consumed first
  output logic [127:0] z_o,
  output logic [127:0] v_o
);
  localparam logic [127:0] R = {8'he1, 120'd0};

  logic [127:0] z_w, v_w;

  always_comb begin
    z_w = z_i;
    v_w = v_i;
    for (int i = 0; i < BITS; i++) begin
      if (x_i[127-i]) z_w = z_w ^ v_w;
      v_w = v_w[0] ? ((v_w >> 1) ^ R) : (v_w >> 1);
    end
    z_o = z_w;
    v_o = v_w;
  end
endmodule

module gcm_tag_check #(
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [0:127] i_h,
  input  logic [0:127] i_encrypted_j0,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [0:127] i_data,
  input  logic         i_is_aad,
  input  logic         i_last,
  input  logic [0:127] i_tag,
  output logic [0:127] o_tag,
  output logic         o_auth_ok,
  output logic         o_done,
  output logic         o_busy
);
  localparam int             STEPS    = 128 / BITS_PER_CYCLE;
  localparam logic [7:0]     LAST_CNT = 8'(STEPS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_MULT, ST_LEN, ST_LMULT, ST_FINAL, ST_DONE
  } state_e;

  state_e       state_q, state_d;

  logic [127:0] h_q, ej0_q, y_q, tag_rx_q, tag_o_q;
  logic [127:0] z_q, v_q, x_q;      // multiply accumulator, shifted H, multiplier
  logic [7:0]   mul_cnt_q;
  logic [31:0]  aad_cnt_q, dat_cnt_q;
  logic         seen_ct_q;          // ciphertext seen: later beats are ciphertext
  logic         last_q;             // beat in MULT carried i_last
  logic         auth_q, done_q;

  // Port views in the internal [127:0] orientation.
  logic [127:0] data_w, h_w, ej0_w, tag_w;
  assign data_w = i_data;
  assign h_w    = i_h;
  assign ej0_w  = i_encrypted_j0;
  assign tag_w  = i_tag;

  logic start_acc, beat_acc, beat_is_ct, mul_last;
  assign start_acc  = i_start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign beat_acc   = i_valid && o_ready;
  assign beat_is_ct = !i_is_aad || seen_ct_q;
  assign mul_last   = (mul_cnt_q == LAST_CNT);

  // The length block uses the block counts scaled to bits (x128), and
  // each count is zero-extended to 64 bits.
  logic [127:0] len_blk, y_fin;
  assign len_blk = {25'd0, aad_cnt_q, 7'd0, 25'd0, dat_cnt_q, 7'd0};
  assign y_fin   = y_q ^ ej0_q;

  logic [127:0] z_nx, v_nx;
  gcm_gf_round #(.BITS(BITS_PER_CYCLE)) u_round (
    .z_i (z_q),
    .v_i (v_q),
    .x_i (x_q),
    .z_o (z_nx),
    .v_o (v_nx)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_acc) state_d = ST_WAIT;
      ST_WAIT:  if (beat_acc)  state_d = ST_MULT;
      ST_MULT:  if (mul_last)  state_d = last_q ? ST_LEN : ST_WAIT;
      ST_LEN:                  state_d = ST_LMULT;
      ST_LMULT: if (mul_last)  state_d = ST_FINAL;
      ST_FINAL:                state_d = ST_DONE;
      ST_DONE:  if (start_acc) state_d = ST_WAIT;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q       <= '0;
      ej0_q     <= '0;
      y_q       <= '0;
      tag_rx_q  <= '0;
      tag_o_q   <= '0;
      z_q       <= '0;
      v_q       <= '0;
      x_q       <= '0;
      mul_cnt_q <= '0;
      aad_cnt_q <= '0;
      dat_cnt_q <= '0;
      seen_ct_q <= 1'b0;
      last_q    <= 1'b0;
      auth_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == ST_FINAL);
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_acc) begin
            h_q       <= h_w;
            ej0_q     <= ej0_w;
            y_q       <= '0;
            aad_cnt_q <= '0;
            dat_cnt_q <= '0;
            seen_ct_q <= 1'b0;
            last_q    <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (beat_acc) begin
            y_q       <= y_q ^ data_w;
            x_q       <= y_q ^ data_w;
            z_q       <= '0;
            v_q       <= h_q;
            mul_cnt_q <= '0;
            last_q    <= i_last;
            if (beat_is_ct) begin
              dat_cnt_q <= dat_cnt_q + 32'd1;
              seen_ct_q <= 1'b1;
            end else begin
              aad_cnt_q <= aad_cnt_q + 32'd1;
            end
            if (i_last) tag_rx_q <= tag_w;
          end
        end
        ST_MULT, ST_LMULT: begin
          z_q       <= z_nx;
          v_q       <= v_nx;
          x_q       <= x_q << BITS_PER_CYCLE;
          mul_cnt_q <= mul_cnt_q + 8'd1;
          if (mul_last) y_q <= z_nx;
        end
        ST_LEN: begin
          y_q       <= y_q ^ len_blk;
          x_q       <= y_q ^ len_blk;
          z_q       <= '0;
          v_q       <= h_q;
          mul_cnt_q <= '0;
        end
        ST_FINAL: begin
          tag_o_q <= y_fin;
          auth_q  <= (y_fin == tag_rx_q);
        end
        default: ;
      endcase
    end
  end

  assign o_ready   = (state_q == ST_WAIT);
  assign o_busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign o_done    = done_q;
  assign o_tag     = tag_o_q;
  assign o_auth_ok = auth_q;
endmodule

// File: tb/tb_gcm_tag_check.sv
module tb_gcm_tag_check;
  localparam int LAT = 34;   // 2*(128/8)+2
  localparam int GAP = 17;   // 128/8 multiply cycles + 1 WAIT cycle

  localparam logic [0:127] H2   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [0:127] EJ2  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [0:127] C2   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [0:127] TAG2 = 128'hab6e47d42cec13bdf53a67b21257bddf;

  localparam logic [0:127] H3   = 128'hb83b533708bf535d0aa6e52980d53b78;
  localparam logic [0:127] EJ3  = 128'h3247184b3c4f69a44dbcd22887bbb418;
  localparam logic [0:127] C3_0 = 128'h42831ec2217774244b7221b784d0d49c;
  localparam logic [0:127] C3_1 = 128'he3aa212f2c02a4e035c17e2329aca12e;
  localparam logic [0:127] C3_2 = 128'h21d514b25466931c7d8f6a5aac84aa05;
  localparam logic [0:127] C3_3 = 128'h1ba30b396a0aac973d58e091473f5985;
  localparam logic [0:127] C4_3 = 128'h1ba30b396a0aac973d58e09100000000;
  localparam logic [0:127] A4_0 = 128'hfeedfacedeadbeeffeedfacedeadbeef;
  localparam logic [0:127] A4_1 = 128'habaddad2000000000000000000000000;
  localparam logic [0:127] TAG3 = 128'h4d5c2af327cd64a62cf35abd2ba6fab4;

  logic         clk = 1'b0;
  logic         rst, i_start, i_valid, i_is_aad, i_last;
  logic [0:127] i_h, i_encrypted_j0, i_data, i_tag;
  logic         o_ready, o_auth_ok, o_done, o_busy;
  logic [0:127] o_tag;

  int n_cmp = 0;
  int n_bad = 0;

  logic [0:127] blk [8];
  logic         isa [8];

  always #5 clk = ~clk;

  gcm_tag_check #(.BITS_PER_CYCLE(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_h            (i_h),
    .i_encrypted_j0 (i_encrypted_j0),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_data         (i_data),
    .i_is_aad       (i_is_aad),
    .i_last         (i_last),
    .i_tag          (i_tag),
    .o_tag          (o_tag),
    .o_auth_ok      (o_auth_ok),
    .o_done         (o_done),
    .o_busy         (o_busy)
  );

  // Reference GF(2^128) multiply, following the textbook right-shift
  // algorithm on [0:127] vectors (bit 0 = MSB).
  function automatic logic [0:127] gmul(input logic [0:127] x, input logic [0:127] y);
    logic [0:127] z = '0;
    logic [0:127] v = y;
    logic [0:127] r = 128'he1000000000000000000000000000000;
    for (int i = 0; i < 128; i++) begin
      if (x[i]) z = z ^ v;
      if (v[127]) v = (v >> 1) ^ r;
      else        v = v >> 1;
    end
    return z;
  endfunction

  // Model tag over blk[0..nb-1]. Block counts are scaled to bits, and a
  // beat after the first ciphertext beat is counted as ciphertext.
  function automatic logic [0:127] model_tag(input logic [0:127] h, input logic [0:127] ej0, input int nb);
    logic [0:127] y = '0;
    logic [0:63]  la, lc;
    int na = 0, nc = 0;
    bit ct = 0;
    for (int k = 0; k < nb; k++) begin
      y = gmul(y ^ blk[k], h);
      if (isa[k] && !ct) na++;
      else begin nc++; ct = 1; end
    end
    la = 64'(na) * 64'd128;
    lc = 64'(nc) * 64'd128;
    y = gmul(y ^ {la, lc}, h);
    return y ^ ej0;
  endfunction

  task automatic do_start(input logic [0:127] h, input logic [0:127] ej0);
    i_start = 1'b1; i_h = h; i_encrypted_j0 = ej0;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // Returns one time unit after the edge that accepted the beat.
  task automatic send_beat(input logic [0:127] d, input logic aad, input logic last,
                           input logic [0:127] tag);
    int w = 0;
    i_valid = 1'b1; i_data = d; i_is_aad = aad; i_last = last; i_tag = tag;
    while (!o_ready && w < 200) begin @(posedge clk); #1; w++; end
    if (w >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_accept: o_ready never rose within %0d cycles", w);
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!o_done && n < 300) begin @(posedge clk); #1; n++; end
  endtask

  task automatic check_session(input string nm, input int n,
                               input logic [0:127] exp_tag, input logic exp_ok);
    n_cmp++;
    if (n !== LAT) begin n_bad++; $display("FAIL %s_latency: got %0d want %0d", nm, n, LAT); end
    n_cmp++;
    if (o_tag !== exp_tag) begin n_bad++; $display("FAIL %s_tag: got %h want %h", nm, o_tag, exp_tag); end
    n_cmp++;
    if (o_auth_ok !== exp_ok) begin n_bad++; $display("FAIL %s_auth: got %b want %b", nm, o_auth_ok, exp_ok); end
    @(posedge clk); #1;
    n_cmp++;
    if (o_done !== 1'b0 || o_tag !== exp_tag) begin
      n_bad++; $display("FAIL %s_hold: done=%b tag=%h want done=0 tag=%h", nm, o_done, o_tag, exp_tag);
    end
  endtask

  task automatic run_msg(input string nm, input logic [0:127] h, input logic [0:127] ej0,
                         input int nb, input logic [0:127] rx_tag,
                         input logic [0:127] exp_tag, input logic exp_ok);
    int n;
    do_start(h, ej0);
    for (int k = 0; k < nb; k++) send_beat(blk[k], isa[k], k == nb - 1, rx_tag);
    wait_done(n);
    check_session(nm, n, exp_tag, exp_ok);
  endtask

  task automatic load_case3();
    blk[0] = C3_0; blk[1] = C3_1; blk[2] = C3_2; blk[3] = C3_3;
    for (int k = 0; k < 8; k++) isa[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b1; i_h = H2; i_encrypted_j0 = EJ2;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    n_cmp++;
    if (o_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", o_ready); end
    n_cmp++;
    if (o_done !== 1'b0 || o_auth_ok !== 1'b0) begin
      n_bad++; $display("FAIL reset_done_auth: got %b%b want 00", o_done, o_auth_ok);
    end
    n_cmp++;
    if (o_tag !== '0) begin n_bad++; $display("FAIL reset_tag: got %h want 0", o_tag); end
    rst = 1'b0; i_start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_case2();
    blk[0] = C2; isa[0] = 1'b0;
    run_msg("case2", H2, EJ2, 1, TAG2, TAG2, 1'b1);
  endtask

  task automatic test_bad_tag();
    logic [0:127] t = TAG2;
    t[127] = ~t[127];
    blk[0] = C2; isa[0] = 1'b0;
    run_msg("badtag", H2, EJ2, 1, t, TAG2, 1'b0);
  endtask

  task automatic test_case3_ct();
    load_case3();
    run_msg("case3", H3, EJ3, 4, TAG3, TAG3, 1'b1);
  endtask

  task automatic test_case4_aad();
    logic [0:127] exp;
    blk[0] = A4_0; blk[1] = A4_1; blk[2] = C3_0; blk[3] = C3_1; blk[4] = C3_2; blk[5] = C4_3;
    isa[0] = 1'b1; isa[1] = 1'b1; isa[2] = 1'b0; isa[3] = 1'b0; isa[4] = 1'b0; isa[5] = 1'b0;
    exp = model_tag(H3, EJ3, 6);
    run_msg("case4_aad", H3, EJ3, 6, exp, exp, 1'b1);
  endtask

  // i_is_aad raised after a ciphertext beat must still count as ciphertext.
  task automatic test_sticky_ct();
    logic [0:127] exp;
    blk[0] = A4_0; blk[1] = C3_0; blk[2] = C3_1;
    isa[0] = 1'b1; isa[1] = 1'b0; isa[2] = 1'b1;
    exp = model_tag(H3, EJ3, 3);
    run_msg("sticky", H3, EJ3, 3, TAG3, exp, 1'b0);
  endtask

  task automatic test_back_to_back();
    int k = 0, cyc = 0, prev = -1, n;
    load_case3();
    do_start(H3, EJ3);
    i_valid = 1'b1; i_is_aad = 1'b0; i_tag = TAG3;
    while (k < 4 && cyc < 400) begin
      i_data = blk[k]; i_last = (k == 3);
      if (o_ready) begin
        if (prev >= 0) begin
          n_cmp++;
          if (cyc - prev !== GAP) begin
            n_bad++; $display("FAIL b2b_gap: got %0d want %0d", cyc - prev, GAP);
          end
        end
        prev = cyc; k++;
      end
      @(posedge clk); #1; cyc++;
    end
    n_cmp++;
    if (k !== 4) begin n_bad++; $display("FAIL b2b_beats: got %0d want 4", k); end
    wait_done(n);
    i_valid = 1'b0; i_last = 1'b0;
    check_session("b2b", n, TAG3, 1'b1);
  endtask

  task automatic test_abort();
    int seen = 0;
    load_case3();
    do_start(H3, EJ3);
    send_beat(blk[0], 1'b0, 1'b0, TAG3);
    send_beat(blk[1], 1'b0, 1'b0, TAG3);
    @(posedge clk); #1;                 // mid-MULT of second beat
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (o_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", o_busy); end
    n_cmp++;
    if (o_tag !== '0) begin n_bad++; $display("FAIL abort_tag: got %h want 0", o_tag); end
    repeat (80) begin
      if (o_done) seen++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL abort_done: got %0d pulses want 0", seen); end
    test_case2();
  endtask

  task automatic test_start_ignored();
    int n;
    do_start(H2, EJ2);
    send_beat(C2, 1'b0, 1'b1, TAG2);
    i_start = 1'b1; i_h = H3; i_encrypted_j0 = EJ3;
    @(posedge clk); #1;
    i_start = 1'b0;
    n_cmp++;
    if (o_busy !== 1'b1) begin n_bad++; $display("FAIL ign_busy: got %b want 1", o_busy); end
    wait_done(n);
    check_session("ign_start", n + 1, TAG2, 1'b1);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_is_aad = 1'b0; i_last = 1'b0;
    i_h = '0; i_encrypted_j0 = '0; i_data = '0; i_tag = '0;
    test_reset();
    test_case2();
    test_bad_tag();
    test_case3_ct();
    test_case4_aad();
    test_sticky_ct();
    test_back_to_back();
    test_abort();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
